// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus the loader write port of the instruction memory.
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic        resp_err;
    logic        ld_we;
    logic [63:0] ld_addr;
    logic [31:0] ld_data;

    modport master (
        output req_valid, req_addr, resp_ready, ld_we, ld_addr, ld_data,
        input  req_ready, resp_valid, resp_instr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, ld_we, ld_addr, ld_data,
        output req_ready, resp_valid, resp_instr, resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory with a LATENCY-stage read pipeline feeding a QDEPTH-entry response FIFO.
// Credit-based req_ready keeps pipeline plus FIFO occupancy at or below QDEPTH.
module imem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int QDEPTH      = 4
) (
    input logic           clk,
    input logic           rst,
    imem_responder_if.slave bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]               mem_q [DEPTH_WORDS];
    logic [LATENCY-1:0]        vld_pipe_q;
    logic [LATENCY-1:0]        err_pipe_q;
    logic [LATENCY-1:0][31:0]  dat_pipe_q;
    logic [31:0]               fifo_dat_q [QDEPTH];
    logic [QDEPTH-1:0]         fifo_err_q;
    logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]             out_cnt_q, out_cnt_d;
    logic                      req_ready_q;

    logic [61:0] rd_idx, ld_idx;
    logic        rd_ok, ld_ok, accept, push, pop, fifo_nempty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        rd_idx      = bus.req_addr[63:2];
        ld_idx      = bus.ld_addr[63:2];
        rd_ok       = (bus.req_addr[1:0] == 2'b00) && (rd_idx < 62'(DEPTH_WORDS));
        ld_ok       = bus.ld_we && (bus.ld_addr[1:0] == 2'b00) && (ld_idx < 62'(DEPTH_WORDS));
        fifo_nempty = (fifo_cnt_q != '0);
        accept      = bus.req_valid && req_ready_q;
        push        = vld_pipe_q[LATENCY-1];
        pop         = fifo_nempty && bus.resp_ready;
    end

    always_ff @(posedge clk) begin
        if (ld_ok) mem_q[ld_idx[AW-1:0]] <= bus.ld_data;
    end

    // Stage 0 samples the array at the accept edge, so a same-edge load write is not seen.
    always_ff @(posedge clk) begin
        if (accept) begin
            err_pipe_q[0] <= !rd_ok;
            dat_pipe_q[0] <= rd_ok ? mem_q[rd_idx[AW-1:0]] : NOP;
        end
        for (int i = 1; i < LATENCY; i++) begin
            err_pipe_q[i] <= err_pipe_q[i-1];
            dat_pipe_q[i] <= dat_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat_q[wr_ptr_q] <= dat_pipe_q[LATENCY-1];
            fifo_err_q[wr_ptr_q] <= err_pipe_q[LATENCY-1];
        end
    end

    always_comb begin
        out_cnt_d  = out_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({accept, pop})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: ;
        endcase
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: ;
        endcase
    end

    // Every in-flight request already owns a FIFO slot, so push never finds the FIFO full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            out_cnt_q   <= '0;
            req_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            fifo_cnt_q  <= fifo_cnt_d;
            out_cnt_q   <= out_cnt_d;
            req_ready_q <= (out_cnt_d < CW'(QDEPTH));
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = fifo_nempty;
    assign bus.resp_instr = fifo_nempty ? fifo_dat_q[rd_ptr_q] : 32'h0;
    assign bus.resp_err   = fifo_nempty ? fifo_err_q[rd_ptr_q] : 1'b0;
endmodule

// File: tb/tb_imem_responder.sv
// Directed plus random checks of imem_responder against a queue-based response model.
module tb_imem_responder;
    localparam int LAT = 2;
    localparam int QD  = 4;
    localparam int DW  = 1024;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    imem_responder_if bus();

    imem_responder #(.DEPTH_WORDS(DW), .LATENCY(LAT), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] dat; logic err; int due; } exp_t;
    typedef struct { logic [31:0] dat; logic err; int cyc; } rsp_t;

    exp_t        q[$];
    rsp_t        rsp_log[$];
    int          acc_log[$];
    logic [31:0] mmem [DW];
    int          cyc = 0;
    int          n_acc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          rdy_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", nm, got, exp, cyc);
        end
    endtask

    // Inputs change 2ns after posedge, so negedge values are exactly what the next edge samples.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
            chk("rst_resp_instr", bus.resp_instr, 32'h0);
            chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
            chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        end else if (cyc > 0) begin
            bit ev;
            ev = (q.size() > 0) && (cyc >= q[0].due);
            chk("resp_valid", 32'(bus.resp_valid), 32'(ev));
            if (ev) begin
                chk("resp_instr", bus.resp_instr, q[0].dat);
                chk("resp_err", 32'(bus.resp_err), 32'(q[0].err));
            end
            chk("req_ready", 32'(bus.req_ready), 32'(rdy_en && (q.size() < QD)));
        end
        cyc++;
        if (rst) begin
            q.delete();
            rdy_en = 1'b0;
        end else begin
            if (bus.resp_valid && bus.resp_ready) begin
                if (q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL pop_unexpected got=%h exp=none", bus.resp_instr);
                end else begin
                    void'(q.pop_front());
                end
                rsp_log.push_back('{bus.resp_instr, bus.resp_err, cyc});
            end
            if (bus.req_valid && bus.req_ready) begin
                exp_t e;
                logic [63:0] a;
                a = bus.req_addr;
                if (a[1:0] != 2'b00 || a[63:2] >= 62'(DW)) e = '{NOP, 1'b1, cyc + LAT};
                else e = '{mmem[a[11:2]], 1'b0, cyc + LAT};
                q.push_back(e);
                acc_log.push_back(cyc);
                n_acc++;
            end
            if (bus.ld_we && bus.ld_addr[1:0] == 2'b00 && bus.ld_addr[63:2] < 62'(DW))
                mmem[bus.ld_addr[11:2]] = bus.ld_data;
            rdy_en = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ld(input logic [63:0] addr, input logic [31:0] data);
        bus.ld_we = 1'b1; bus.ld_addr = addr; bus.ld_data = data;
        tick();
        bus.ld_we = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] addr);
        int  t;
        bit  acc;
        t = 0;
        bus.req_valid = 1'b1; bus.req_addr = addr;
        do begin
            acc = bus.req_ready;
            tick();
            t++;
        end while (!acc && t < 200);
        if (!acc) begin
            n_chk++; n_err++;
            $display("FAIL fetch_timeout got=not_accepted exp=accepted addr=%h", addr);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] prog [4];
        logic [63:0] a3   [5];
        int b, a, k, n0, c, start;
        prog[0] = 32'h00A00093; prog[1] = 32'h00B00113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000073;
        a3[0] = 64'h0; a3[1] = 64'h4; a3[2] = 64'h8; a3[3] = 64'hC; a3[4] = 64'h10;

        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b1;
        bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        idle(2);
        rst = 1'b0;

        for (int i = 0; i < DW; i++) ld(64'(i) << 2, 32'(i) * 32'h9E3779B9 + 32'h1234);
        for (int i = 0; i < 4; i++) ld(64'(i) << 2, prog[i]);
        ld(64'h2, 32'hBAD0BAD0);      // misaligned: must be ignored
        ld(64'h1000, 32'hBAD1BAD1);   // out of range: must be ignored

        // back-to-back in-order fetch with fixed latency
        b = rsp_log.size(); a = acc_log.size();
        for (int i = 0; i < 4; i++) fetch(a3[i]);
        idle(6);
        chk("t1_count", 32'(rsp_log.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", rsp_log[b+i].dat, prog[i]);
            chk("t1_err", 32'(rsp_log[b+i].err), 32'h0);
            chk("t1_timing", 32'(rsp_log[b+i].cyc - acc_log[a]), 32'(LAT + 1 + i));
        end

        // misaligned and out-of-range fetches
        b = rsp_log.size();
        fetch(64'h6); fetch(64'h1000);
        idle(6);
        chk("t2_count", 32'(rsp_log.size() - b), 32'd2);
        chk("t2_mis_data", rsp_log[b].dat, NOP);
        chk("t2_mis_err", 32'(rsp_log[b].err), 32'h1);
        chk("t2_oor_data", rsp_log[b+1].dat, NOP);
        chk("t2_oor_err", 32'(rsp_log[b+1].err), 32'h1);

        // backpressure: credits run out at exactly QDEPTH
        b = rsp_log.size();
        bus.resp_ready = 1'b0; bus.req_valid = 1'b1; k = 0;
        for (int i = 0; i < 8; i++) begin
            bit acc;
            bus.req_addr = a3[k];
            acc = bus.req_ready;
            tick();
            if (acc) k++;
        end
        bus.req_valid = 1'b0;
        chk("t3_accepted", 32'(k), 32'd4);
        chk("t3_ready_low", 32'(bus.req_ready), 32'h0);
        chk("t3_head", bus.resp_instr, prog[0]);
        bus.resp_ready = 1'b1;
        idle(8);
        chk("t3_count", 32'(rsp_log.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) chk("t3_data", rsp_log[b+i].dat, prog[i]);
        chk("t3_ready_back", 32'(bus.req_ready), 32'h1);

        // same-edge load and fetch reads old data
        b = rsp_log.size();
        bus.ld_we = 1'b1; bus.ld_addr = 64'h8; bus.ld_data = 32'hDEADBEEF;
        bus.req_valid = 1'b1; bus.req_addr = 64'h8;
        tick();
        bus.ld_we = 1'b0; bus.req_valid = 1'b0;
        fetch(64'h8);
        idle(6);
        chk("t4_old", rsp_log[b].dat, 32'h002081B3);
        chk("t4_new", rsp_log[b+1].dat, 32'hDEADBEEF);

        // reset with requests outstanding
        bus.resp_ready = 1'b0;
        fetch(64'h0); fetch(64'h4); fetch(64'h8);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_valid_async", 32'(bus.resp_valid), 32'h0);
        chk("t5_ready_async", 32'(bus.req_ready), 32'h0);
        idle(2);
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        n0 = rsp_log.size();
        idle(10);
        chk("t5_no_stale", 32'(rsp_log.size()), 32'(n0));
        b = rsp_log.size();
        for (int i = 0; i < 4; i++) fetch(a3[i]);
        idle(6);
        chk("t5_mem0", rsp_log[b].dat, prog[0]);
        chk("t5_mem1", rsp_log[b+1].dat, prog[1]);
        chk("t5_mem2", rsp_log[b+2].dat, 32'hDEADBEEF);
        chk("t5_mem3", rsp_log[b+3].dat, prog[3]);

        // random traffic against the model
        start = n_acc; c = 0;
        while (n_acc - start < 10000 && c < 60000) begin
            int r;
            bus.req_valid  = ($urandom_range(0, 9) < 7);
            bus.resp_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 15);
            if (r == 0)      bus.req_addr = (64'($urandom_range(0, DW-1)) << 2) | 64'($urandom_range(1, 3));
            else if (r == 1) bus.req_addr = 64'($urandom_range(DW, 4*DW)) << 2;
            else             bus.req_addr = 64'($urandom_range(0, DW-1)) << 2;
            bus.ld_we = ($urandom_range(0, 9) == 0);
            bus.ld_addr = ($urandom_range(0, 7) == 0) ? 64'h1000 : (64'($urandom_range(0, DW-1)) << 2);
            bus.ld_data = $urandom;
            tick();
            c++;
        end
        bus.req_valid = 1'b0; bus.ld_we = 1'b0; bus.resp_ready = 1'b1;
        if (c >= 60000) begin
            n_chk++; n_err++;
            $display("FAIL rand_timeout got=%0d exp=10000 accepts", n_acc - start);
        end
        c = 0;
        while (q.size() != 0 && c < 100) begin tick(); c++; end
        chk("drain_empty", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
